// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO, LSB-first framing and back-to-back frames.
// Ports: i_Clock/i_Reset (sync, active high); i_Tx_DV/i_Tx_Data write side, o_Tx_Ready = FIFO not full,
// o_Fifo_Count words held, o_Overflow pulse on a rejected write; o_Tx_Serial line, o_Tx_Active frame in
// progress, o_Tx_Done pulse after each frame. Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD sense).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Tx_DV,
  input  logic [DATA_BITS-1:0]             i_Tx_Data,
  output logic                             o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Fifo_Count,
  output logic                             o_Overflow,
  output logic                             o_Tx_Active,
  output logic                             o_Tx_Serial,
  output logic                             o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [NW-1:0]        count_q;
  logic                 serial_q, active_q, fin_q, done_q, ovf_q;
  logic                 push, pop, baud_end, bit_last, stop_last, line_d, active_d;
  assign o_Tx_Ready   = count_q != NW'(FIFO_DEPTH);
  assign o_Fifo_Count = count_q;
  assign o_Overflow   = ovf_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Done    = done_q;
  assign push      = i_Tx_DV && o_Tx_Ready;
  assign baud_end  = baud_q == CW'(CLKS_PER_BIT - 1);
  assign bit_last  = bit_q == BW'(DATA_BITS - 1);
  // bit_q doubles as the stop-bit counter, so multi-stop frames need no extra counter
  assign stop_last = bit_q == BW'(STOP_BITS - 1);
  // a word is loaded from IDLE, or straight out of the last stop cycle for gapless framing
  assign pop = count_q != '0 && (state_q == S_IDLE || (state_q == S_STOP && baud_end && stop_last));
`ifdef UART_TX_PARITY_EN
  logic par;
  assign par = ^data_q ^ PARITY_ODD[0];
`endif
  // outputs are registered from the current state, so the line trails the FSM by one cycle
  always_comb begin
    line_d = state_q == S_START ? 1'b0 :
             state_q == S_DATA  ? data_q[bit_q] :
`ifdef UART_TX_PARITY_EN
             state_q == S_PARITY ? par :
`endif
             1'b1;
    active_d = state_q != S_IDLE && state_q <= S_STOP;
  end
  always_ff @(posedge i_Clock)
    if (push) mem_q[wr_q] <= i_Tx_Data;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q  <= count_q + NW'(push) - NW'(pop);
      ovf_q    <= i_Tx_DV && !o_Tx_Ready;
      serial_q <= line_d;
      active_q <= active_d;
      // done lands one cycle after the line's final stop cycle, which itself trails the FSM
      fin_q    <= state_q == S_STOP && baud_end && stop_last;
      done_q   <= fin_q;
      baud_q   <= (state_q == S_IDLE || baud_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          bit_q <= '0;
          if (pop) begin
            data_q  <= mem_q[rd_q];
            state_q <= S_START;
          end
        end
        S_START: if (baud_end) state_q <= S_DATA;
        S_DATA: if (baud_end) begin
          bit_q <= bit_last ? '0 : bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_last) state_q <= S_PARITY;
`else
          if (bit_last) state_q <= S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (baud_end) state_q <= S_STOP;
`endif
        S_STOP: if (baud_end) begin
          bit_q <= stop_last ? '0 : bit_q + 1'b1;
          if (stop_last) begin
            if (pop) data_q <= mem_q[rd_q];
            state_q <= pop ? S_START : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a waveform-level frame model.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       a_dv = 1'b0, a_rdy, a_ovf, a_act, a_ser, a_done;
  logic [7:0] a_data = '0;
  logic [2:0] a_cnt;
  logic       b_dv = 1'b0, b_rdy, b_ovf, b_act, b_ser, b_done;
  logic [6:0] b_data = '0;
  logic [1:0] b_cnt;
  int total = 0;
  int bad = 0;
  bit expq[$];
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(a_dv), .i_Tx_Data(a_data), .o_Tx_Ready(a_rdy),
    .o_Fifo_Count(a_cnt), .o_Overflow(a_ovf), .o_Tx_Active(a_act), .o_Tx_Serial(a_ser), .o_Tx_Done(a_done));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(2), .PARITY_ODD(1)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(b_dv), .i_Tx_Data(b_data), .o_Tx_Ready(b_rdy),
    .o_Fifo_Count(b_cnt), .o_Overflow(b_ovf), .o_Tx_Active(b_act), .o_Tx_Serial(b_ser), .o_Tx_Done(b_done));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int which, input logic v, input logic [8:0] w);
    if (which == 0) begin
      a_dv = v;
      a_data = w[7:0];
    end else begin
      b_dv = v;
      b_data = w[6:0];
    end
  endtask
  // expected line, one entry per clock: start, data LSB first, optional parity, stop bits
  function automatic void add_frame(input int d, input int s, input int odd, input logic [8:0] w);
    bit par;
    par = odd[0];
    repeat (CPB) expq.push_back(1'b0);
    for (int i = 0; i < d; i++) begin
      par ^= w[i];
      repeat (CPB) expq.push_back(w[i]);
    end
    if (P == 1) repeat (CPB) expq.push_back(par);
    repeat (s * CPB) expq.push_back(1'b1);
  endfunction
  // writes wr on consecutive cycles, expects the words ex back-to-back starting 2 cycles after the first accept
  task automatic run_stream(input int which, input logic [8:0] wr[$], input logic [8:0] ex[$], input string name,
                            output int peak, output int ovfs, output int nrdy);
    int d, s, fl, n, cnt;
    logic ser, act, dn, rdy, ovf, el, ea, ed;
    d = which == 0 ? 8 : 7;
    s = which == 0 ? 1 : 2;
    fl = (1 + d + P + s) * CPB;
    n = 2 + ex.size() * fl + 8;
    peak = 0;
    ovfs = 0;
    nrdy = 0;
    cnt = 0;
    expq.delete();
    repeat (2) expq.push_back(1'b1);
    foreach (ex[i]) add_frame(d, s, which, ex[i]);
    drive(which, 1'b1, wr[0]);
    for (int k = 0; k < n; k++) begin
      step();
      ser = which == 0 ? a_ser : b_ser;
      act = which == 0 ? a_act : b_act;
      dn  = which == 0 ? a_done : b_done;
      rdy = which == 0 ? a_rdy : b_rdy;
      ovf = which == 0 ? a_ovf : b_ovf;
      cnt = which == 0 ? int'(a_cnt) : int'(b_cnt);
      if (k + 1 < wr.size()) drive(which, 1'b1, wr[k+1]);
      else drive(which, 1'b0, 9'h0);
      el = k < expq.size() ? expq[k] : 1'b1;
      ea = k >= 2 && k < 2 + ex.size() * fl;
      ed = k >= 2 + fl && (k - 2) % fl == 0 && (k - 2) / fl <= ex.size();
      total++;
      if (ser !== el) begin
        bad++;
        $display("FAIL %s line k=%0d got=%b exp=%b", name, k, ser, el);
      end
      total++;
      if (act !== ea) begin
        bad++;
        $display("FAIL %s active k=%0d got=%b exp=%b", name, k, act, ea);
      end
      total++;
      if (dn !== ed) begin
        bad++;
        $display("FAIL %s done k=%0d got=%b exp=%b", name, k, dn, ed);
      end
      if (cnt > peak) peak = cnt;
      if (ovf === 1'b1) ovfs++;
      if (rdy !== 1'b1) nrdy++;
    end
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL %s final_count got=%0d exp=0", name, cnt);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total += 9;
    if (a_ser !== 1'b1) begin bad++; $display("FAIL reset a_serial got=%b exp=1", a_ser); end
    if (a_act !== 1'b0) begin bad++; $display("FAIL reset a_active got=%b exp=0", a_act); end
    if (a_done !== 1'b0) begin bad++; $display("FAIL reset a_done got=%b exp=0", a_done); end
    if (a_ovf !== 1'b0) begin bad++; $display("FAIL reset a_overflow got=%b exp=0", a_ovf); end
    if (a_rdy !== 1'b1) begin bad++; $display("FAIL reset a_ready got=%b exp=1", a_rdy); end
    if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset a_count got=%0d exp=0", a_cnt); end
    if (b_ser !== 1'b1) begin bad++; $display("FAIL reset b_serial got=%b exp=1", b_ser); end
    if (b_rdy !== 1'b1) begin bad++; $display("FAIL reset b_ready got=%b exp=1", b_rdy); end
    if (b_cnt !== 2'd0) begin bad++; $display("FAIL reset b_count got=%0d exp=0", b_cnt); end
    rst = 1'b0;
    repeat (2) step();
  endtask
  task automatic test_single();
    logic [8:0] w[$];
    int pk, ov, nr;
    w.push_back(9'h0A5);
    run_stream(0, w, w, "single_a5", pk, ov, nr);
  endtask
  task automatic test_back_to_back();
    logic [8:0] w[$];
    int pk, ov, nr;
    for (int i = 1; i <= 3; i++) w.push_back(9'(i));
    run_stream(0, w, w, "b2b", pk, ov, nr);
  endtask
  task automatic test_overflow();
    logic [8:0] wr[$], ex[$];
    int pk, ov, nr;
    for (int i = 1; i <= 6; i++) wr.push_back(9'(8'h10 + i));
    for (int i = 1; i <= 5; i++) ex.push_back(9'(8'h10 + i));
    run_stream(0, wr, ex, "overflow", pk, ov, nr);
    total += 3;
    if (pk !== 4) begin bad++; $display("FAIL overflow peak_count got=%0d exp=4", pk); end
    if (ov !== 1) begin bad++; $display("FAIL overflow pulses got=%0d exp=1", ov); end
    if (nr == 0) begin bad++; $display("FAIL overflow ready_low_cycles got=%0d exp>0", nr); end
  endtask
  task automatic test_frame_format();
    logic [8:0] w[$];
    int pk, ov, nr;
    w.push_back(9'h055);
    run_stream(1, w, w, "d7s2_55", pk, ov, nr);
  endtask
  task automatic test_parity();
    logic [8:0] w[$];
    int pk, ov, nr;
    w.push_back(9'h007);
    run_stream(0, w, w, "parity_even_07", pk, ov, nr);
    run_stream(1, w, w, "parity_odd_07", pk, ov, nr);
  endtask
  task automatic test_random();
    logic [8:0] w[$];
    int pk, ov, nr;
    for (int r = 0; r < 4; r++) begin
      w.delete();
      repeat ($urandom_range(1, 3)) w.push_back(9'($urandom_range(0, 255)));
      run_stream(r % 2, w, w, "random", pk, ov, nr);
    end
  endtask
  task automatic test_reset_mid();
    logic [8:0] w[3];
    int lows, acts, dones;
    w[0] = 9'h0F;
    w[1] = 9'h33;
    w[2] = 9'h3C;
    drive(0, 1'b1, w[0]);
    for (int k = 0; k < 19; k++) begin
      step();
      if (k + 1 < 3) drive(0, 1'b1, w[k+1]);
      else drive(0, 1'b0, 9'h0);
    end
    rst = 1'b1;
    step();
    total += 5;
    if (a_ser !== 1'b1) begin bad++; $display("FAIL reset_mid serial got=%b exp=1", a_ser); end
    if (a_act !== 1'b0) begin bad++; $display("FAIL reset_mid active got=%b exp=0", a_act); end
    if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_mid count got=%0d exp=0", a_cnt); end
    if (a_done !== 1'b0) begin bad++; $display("FAIL reset_mid done got=%b exp=0", a_done); end
    if (a_rdy !== 1'b1) begin bad++; $display("FAIL reset_mid ready got=%b exp=1", a_rdy); end
    rst = 1'b0;
    lows = 0;
    acts = 0;
    dones = 0;
    repeat (150) begin
      step();
      if (a_ser !== 1'b1) lows++;
      if (a_act !== 1'b0) acts++;
      if (a_done !== 1'b0) dones++;
    end
    total += 3;
    if (lows != 0) begin bad++; $display("FAIL reset_mid line_low_cycles got=%0d exp=0", lows); end
    if (acts != 0) begin bad++; $display("FAIL reset_mid active_cycles got=%0d exp=0", acts); end
    if (dones != 0) begin bad++; $display("FAIL reset_mid done_pulses got=%0d exp=0", dones); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_frame_format();
    test_parity();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
